// File: rtl/plot_sink_if.sv
// Plot-side and framebuffer-side signals of the plot sink, bundled with
// modports for the plot source/framebuffer (master) and the sink itself (slave).
interface plot_sink_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [2:0]  colour;
   logic        writeEn;
   logic        clear;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_wren;
   logic        fb_ready;
   logic        busy;
   logic        overflow;
   logic [15:0] clip_count;

   modport master (
      output x, y, colour, writeEn, clear, fb_ready,
      input  fb_addr, fb_data, fb_wren, busy, overflow, clip_count
   );

   modport slave (
      input  x, y, colour, writeEn, clear, fb_ready,
      output fb_addr, fb_data, fb_wren, busy, overflow, clip_count
   );
endinterface

// File: rtl/plot_sink.sv
// Pixel plot sink: clips plots to the screen, queues them in a small FIFO and
// drains them to the framebuffer through a registered valid/ready stage.
module plot_sink #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   plot_sink_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   function automatic logic [14:0] pix_addr(input logic [9:0] row, input logic [9:0] col);
      logic [31:0] a;
      a = 32'(row) * 32'(WIDTH) + 32'(col);
      return a[14:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state, state_nxt;
   logic [17:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCC_W-1:0]  occ;
   logic [14:0]       out_addr_p1;
   logic [2:0]        out_data_p1;
   logic              overflow_q;
   logic [15:0]       clip_q;
   logic              pop, push, drop, clip;

   // p0: sample stage -- qualify the plot and form its word address
   logic              vld_p0, in_range_p0;
   logic [14:0]       addr_p0;

   assign vld_p0      = bus.writeEn && !bus.clear;
   assign in_range_p0 = (32'(bus.x) < 32'(WIDTH)) && (32'(bus.y) < 32'(HEIGHT));
   assign addr_p0     = pix_addr(bus.y, bus.x);

   // A full queue can still take a plot when the head leaves on the same edge.
   assign push = vld_p0 && in_range_p0 && ((occ != OCC_FULL) || pop);
   assign drop = vld_p0 && in_range_p0 && !((occ != OCC_FULL) || pop);
   assign clip = vld_p0 && !in_range_p0;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (occ != '0) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.fb_ready) begin
               if (occ != '0) pop = 1'b1;
               else           state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.clear) begin
         pop       = 1'b0;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {addr_p0, bus.colour};
   end

   // p1: queue bookkeeping and registered framebuffer request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         overflow_q  <= 1'b0;
         clip_q      <= '0;
         out_addr_p1 <= '0;
         out_data_p1 <= '0;
      end else if (bus.clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         overflow_q <= 1'b0;
         clip_q     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            out_addr_p1 <= mem[rd_ptr][17:3];
            out_data_p1 <= mem[rd_ptr][2:0];
         end
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
         if (drop) overflow_q <= 1'b1;
         if (clip) clip_q <= sat_inc(clip_q);
      end
   end

   assign bus.fb_wren    = (state == ISSUE);
   assign bus.fb_addr    = out_addr_p1;
   assign bus.fb_data    = out_data_p1;
   assign bus.busy       = (occ != '0) || (state == ISSUE);
   assign bus.overflow   = overflow_q;
   assign bus.clip_count = clip_q;

endmodule

// File: tb/tb_plot_sink.sv
// Bench for plot_sink: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_plot_sink;
   localparam int WIDTH  = 160;
   localparam int HEIGHT = 120;
   localparam int DEPTH  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   plot_sink_if bus();

   plot_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending {addr,colour} words plus the
   // word currently offered to the framebuffer.
   logic [17:0] mq[$];
   logic        m_wren = 1'b0;
   logic [14:0] m_addr = '0;
   logic [2:0]  m_data = '0;
   logic        m_ov   = 1'b0;
   logic [15:0] m_clip = '0;
   logic        m_xfer, m_pop, m_room;
   logic [17:0] m_e;
   logic [31:0] m_a;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_wren = 1'b0; m_addr = '0; m_data = '0; m_ov = 1'b0; m_clip = '0;
      end else if (bus.clear) begin
         mq.delete();
         m_wren = 1'b0; m_ov = 1'b0; m_clip = '0;
      end else begin
         m_xfer = m_wren && bus.fb_ready;
         m_pop  = (mq.size() != 0) && (!m_wren || m_xfer);
         m_room = (mq.size() < DEPTH) || m_pop;
         if (m_pop) begin
            m_e    = mq.pop_front();
            m_addr = m_e[17:3];
            m_data = m_e[2:0];
            m_wren = 1'b1;
         end else if (m_xfer) begin
            m_wren = 1'b0;
         end
         if (bus.writeEn) begin
            if (int'(bus.x) < WIDTH && int'(bus.y) < HEIGHT) begin
               m_a = 32'(int'(bus.y) * WIDTH + int'(bus.x));
               if (m_room) mq.push_back({m_a[14:0], bus.colour});
               else        m_ov = 1'b1;
            end else if (m_clip != 16'hFFFF) begin
               m_clip = m_clip + 16'd1;
            end
         end
      end
   end

   // Compare process plus a log of the words the DUT actually hands over.
   logic [17:0] dut_log[$];
   int          dut_cyc[$];

   always @(negedge clk) begin
      chk("fb_wren",    32'(bus.fb_wren),    32'(m_wren));
      chk("fb_addr",    32'(bus.fb_addr),    32'(m_addr));
      chk("fb_data",    32'(bus.fb_data),    32'(m_data));
      chk("busy",       32'(bus.busy),       32'((mq.size() != 0) || m_wren));
      chk("overflow",   32'(bus.overflow),   32'(m_ov));
      chk("clip_count", 32'(bus.clip_count), 32'(m_clip));
      if (bus.fb_wren && bus.fb_ready && !reset) begin
         dut_log.push_back({bus.fb_addr, bus.fb_data});
         dut_cyc.push_back(cyc);
      end
   end

   function automatic logic [31:0] log_word(input int i);
      return (dut_log.size() > i) ? 32'(dut_log[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic int log_gap(input int i);
      return (dut_cyc.size() > i + 1) ? dut_cyc[i+1] - dut_cyc[i] : -1;
   endfunction

   task automatic drive(input logic wen, input int xx, input int yy, input logic [2:0] col,
                        input logic clr, input logic rdy);
      @(posedge clk);
      #2;
      bus.writeEn  = wen;
      bus.x        = 10'(xx);
      bus.y        = 10'(yy);
      bus.colour   = col;
      bus.clear    = clr;
      bus.fb_ready = rdy;
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) drive(1'b0, 0, 0, 3'd0, 1'b0, rdy);
   endtask

   task automatic flush(input logic rdy);
      drive(1'b0, 0, 0, 3'd0, 1'b1, rdy);
      #1;
      dut_log.delete();
      dut_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.writeEn = 1'b0; bus.x = '0; bus.y = '0; bus.colour = '0;
      bus.clear = 1'b0; bus.fb_ready = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("rst_wren",  32'(bus.fb_wren),    32'd0);
      chk("rst_addr",  32'(bus.fb_addr),    32'd0);
      chk("rst_busy",  32'(bus.busy),       32'd0);
      chk("rst_clip",  32'(bus.clip_count), 32'd0);
      chk("rst_ovf",   32'(bus.overflow),   32'd0);

      // single pixel
      flush(1'b1);
      drive(1'b1, 5, 2, 3'b100, 1'b0, 1'b1);
      idle(4, 1'b1);
      chk("single_count", 32'(dut_log.size()), 32'd1);
      chk("single_word",  log_word(0), 32'({15'd325, 3'b100}));
      chk("single_busy",  32'(bus.busy), 32'd0);

      // corner pixel then two clipped plots
      flush(1'b1);
      drive(1'b1, 159, 119, 3'd1, 1'b0, 1'b1);
      drive(1'b1, 160, 0,   3'd2, 1'b0, 1'b1);
      drive(1'b1, 0,   120, 3'd3, 1'b0, 1'b1);
      idle(4, 1'b1);
      chk("clip_count_n", 32'(dut_log.size()), 32'd1);
      chk("clip_word",    log_word(0), 32'({15'd19199, 3'd1}));
      chk("clip_cnt",     32'(bus.clip_count), 32'd2);
      chk("clip_ovf",     32'(bus.overflow), 32'd0);

      // six plots into a stalled sink: five kept, sixth dropped
      flush(1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 10 + i, 3, 3'(i), 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("stall_ovf",  32'(bus.overflow), 32'd1);
      chk("stall_none", 32'(dut_log.size()), 32'd0);
      idle(8, 1'b1);
      chk("stall_count", 32'(dut_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("stall_word", log_word(i), 32'({15'(490 + i), 3'(i)}));
      for (int i = 0; i < 4; i++) chk("stall_b2b", 32'(log_gap(i)), 32'd1);

      // full queue, pop and push on the same edge
      flush(1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 20 + i, 0, 3'(i), 1'b0, 1'b0);
      drive(1'b1, 50, 0, 3'd7, 1'b0, 1'b1);
      idle(8, 1'b1);
      chk("full_ovf",   32'(bus.overflow), 32'd0);
      chk("full_count", 32'(dut_log.size()), 32'd6);
      chk("full_last",  log_word(5), 32'({15'd50, 3'd7}));

      // ready toggling during a burst of three
      flush(1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, 30 + i, 5, 3'(i + 1), 1'b0, 1'(i % 2));
      for (int k = 0; k < 10; k++) idle(1, 1'(k % 2));
      chk("tog_count", 32'(dut_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) chk("tog_word", log_word(i), 32'({15'(830 + i), 3'(i + 1)}));

      // asynchronous reset with pixels pending
      flush(1'b0);
      drive(1'b1, 500, 0, 3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 40 + i, 1, 3'd2, 1'b0, 1'b0);
      idle(1, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_wren", 32'(bus.fb_wren),    32'd0);
      chk("arst_busy", 32'(bus.busy),       32'd0);
      chk("arst_clip", 32'(bus.clip_count), 32'd0);
      chk("arst_addr", 32'(bus.fb_addr),    32'd0);
      @(posedge clk);
      #2;
      bus.writeEn = 1'b1; bus.x = 10'd1; bus.y = 10'd1; bus.colour = 3'd6;
      bus.clear = 1'b0; bus.fb_ready = 1'b1;
      #1 reset = 1'b0;
      idle(5, 1'b1);
      chk("arst_count", 32'(dut_log.size()), 32'd1);
      chk("arst_word",  log_word(0), 32'({15'd161, 3'd6}));

      // randomized traffic with stall phases
      flush(1'b1);
      begin
         int ready_bias;
         ready_bias = 2;
         for (int c = 0; c < 800; c++) begin
            if (c % 25 == 0) ready_bias = int'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 175)),
                  int'($urandom_range(0, 135)),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 60) == 0),
                  1'(int'($urandom_range(0, 3)) < ready_bias + 1));
         end
      end
      idle(12, 1'b1);
      chk("rand_drain_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
